sync_fifo_ptr: RTL and testbench
================================

Name: sync_fifo_ptr

Overview:
- Single-clock synchronous FIFO for general data buffering between producer and consumer logic in the same clock domain.
- Dual-port register array with binary read/write pointers, each carrying one extra wrap bit.
- Full and empty are decoded directly from the pointers, not from an occupancy counter.
- Registered read data; writes and reads are ignored when full and empty respectively.

Parameters:
- DATA_WIDTH, 8, width of each stored word in bits.
- DATA_DEPTH, 16, number of entries. Must be a power of two and at least 2.
- ADDR_WIDTH (localparam), $clog2(DATA_DEPTH), address bits. Pointers are ADDR_WIDTH+1 bits.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  write data, sampled at the rising clk edge when the write is accepted.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_out  output  DATA_WIDTH  registered read data.
- empty  output  1  FIFO holds 0 entries.
- full  output  1  FIFO holds DATA_DEPTH entries.

Behaviour:
- Reset:
  - Asserting rst_n=0 immediately clears wr_ptr, rd_ptr and data_out to 0. This happens regardless of clk.
  - Outputs during and after reset: empty=1, full=0, data_out=0.
  - Memory contents are not reset and are don't-care.
  - Reset mid-operation discards all stored data; the FIFO is empty on release.
- Write:
  - Accepted at the rising edge when wr_en=1 and full=0.
  - mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in; wr_ptr increments by 1, wrapping modulo 2*DATA_DEPTH.
  - wr_en=1 while full=1 is dropped: no pointer change, no memory change, no error flag.
- Read:
  - Accepted at the rising edge when rd_en=1 and empty=0.
  - data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]]; rd_ptr increments by 1, wrapping modulo 2*DATA_DEPTH.
  - Read latency is 1 cycle: data_out is valid after the accepting edge and holds until the next accepted read.
  - rd_en=1 while empty=1 is dropped: data_out holds its previous value, rd_ptr unchanged.
- Flags:
  - Combinational decode of the registered pointers; no output glitches beyond pointer update.
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) and (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]).
  - Flags update in the same cycle as the pointer change. empty deasserts after the first accepted write; full asserts after the DATA_DEPTH-th net write.
- Simultaneous wr_en=1 and rd_en=1:
  - Each is qualified independently against the pre-edge flags.
  - Neither full nor empty: both occur, occupancy unchanged, data_out gets the oldest entry.
  - Empty: only the write occurs. The new word is not forwarded to data_out; empty deasserts next cycle.
  - Full: only the read occurs. The incoming word is dropped; full deasserts next cycle.
- Wrap-around: the pointer's low bits address memory, and the wrap bit distinguishes full from empty. Data order is preserved across any number of wraps.
- Storage is inferred RAM/registers (no vendor macros), with no bypass paths.

Test Plan:
- Reset, then write 0xAA (one cycle wr_en), then read (one cycle rd_en) -> empty 1→0→1; data_out=0xAA after the read edge.
- Write 0x00..0x0F (16 writes) -> full=1 after the 16th; then write 0xFF -> dropped, full stays 1, pointers unchanged.
- From full, 16 reads -> data_out sequence 0x00..0x0F, empty=1 after the 16th; a 17th read -> data_out holds 0x0F, empty stays 1.
- Write 0x0A..0x11 (8 entries), then 10 cycles of simultaneous wr/rd with random data -> reads return 0x0A..0x11 then the first two random words in order; full=0, empty=0 throughout.
- Fill to full and issue simultaneous wr/rd -> read returns the oldest entry, the write is dropped, full=0 next cycle. From empty, issue simultaneous wr/rd -> write only, data_out unchanged, empty=0 next cycle.
- Write 5 entries, assert rst_n=0 between clock edges -> data_out=0 and empty=1 immediately; after release, a write of 0x3C followed by a read returns 0x3C.

Source files
------------

// File: rtl/sync_fifo_ptr.sv
// Single-clock FIFO with extra-wrap-bit binary pointers; flags decoded from pointers.
// Latency: one cycle from an accepted read to data_out; a written word is readable the cycle after the write.
// Backpressure: writes while full and reads while empty are silently dropped.
module sync_fifo_ptr #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
);

  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags come straight from the pointers; the top bit separates a full lap from empty.
  always_comb begin
    empty  = (wr_ptr == rd_ptr);
    full   = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
             (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    wr_acc = wr_en && !full;
    rd_acc = rd_en && !empty;
  end

  // Storage array: no reset, contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  // Write pointer advances on every accepted write, wrapping over 2*DATA_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (wr_acc) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer and registered output; data_out holds between accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      rd_ptr   <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ptr.sv
// Directed bench for sync_fifo_ptr with default parameters (8-bit, 16 deep).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-derived constants plus a small queue for the streaming case.
module tb_sync_fifo_ptr;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_out;
  logic       empty;
  logic       full;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_q [$];
  logic [7:0] rnd;
  logic [7:0] exp_v;

  sync_fifo_ptr #(.DATA_WIDTH(8), .DATA_DEPTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;

    // Reset state
    #12;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", data_out, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write then single read
    cycle(1, 0, 8'hAA);
    chk("t1_empty_after_wr", empty, 0);
    cycle(0, 1, 8'h00);
    chk("t1_dout", data_out, 8'hAA);
    chk("t1_empty_after_rd", empty, 1);

    // Fill to full, then attempt an overflow write
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 8'(i));
      if (i == 14) chk("t2_not_full_15", full, 0);
    end
    chk("t2_full", full, 1);
    chk("t2_not_empty", empty, 0);
    cycle(1, 0, 8'hFF);
    chk("t2_full_after_drop", full, 1);

    // Drain in order; the dropped 0xFF must not appear
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 8'h00);
      chk("t3_dout", data_out, 8'(i));
      chk("t3_empty", empty, (i == 15) ? 1 : 0);
      if (i == 0) chk("t3_full_clear", full, 0);
    end
    cycle(0, 1, 8'h00);
    chk("t3_underflow_hold", data_out, 8'h0F);
    chk("t3_underflow_empty", empty, 1);

    // Half full, then simultaneous write and read streaming
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 8'(8'h0A + i));
      model_q.push_back(8'(8'h0A + i));
    end
    for (int k = 0; k < 10; k++) begin
      rnd   = 8'($urandom_range(0, 255));
      exp_v = model_q.pop_front();
      model_q.push_back(rnd);
      cycle(1, 1, rnd);
      chk("t4_dout", data_out, exp_v);
      chk("t4_full", full, 0);
      chk("t4_empty", empty, 0);
    end
    for (int k = 0; k < 8; k++) begin
      exp_v = model_q.pop_front();
      cycle(0, 1, 8'h00);
      chk("t4_drain", data_out, exp_v);
    end
    chk("t4_empty_end", empty, 1);

    // Simultaneous access while full: read only
    for (int i = 0; i < 16; i++) cycle(1, 0, 8'(8'h40 + i));
    chk("t5_full", full, 1);
    cycle(1, 1, 8'h99);
    chk("t5_dout_oldest", data_out, 8'h40);
    chk("t5_full_clear", full, 0);
    for (int i = 1; i < 16; i++) begin
      cycle(0, 1, 8'h00);
      chk("t5_drain", data_out, 8'(8'h40 + i));
    end
    chk("t5_empty", empty, 1);

    // Simultaneous access while empty: write only, no forwarding
    cycle(1, 1, 8'h77);
    chk("t5_no_forward", data_out, 8'h4F);
    chk("t5_empty_clear", empty, 0);
    cycle(0, 1, 8'h00);
    chk("t5_read_77", data_out, 8'h77);
    chk("t5_empty_again", empty, 1);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h50 + i));
    chk("t6_pre_empty", empty, 0);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_dout", data_out, 8'h00);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_full", full, 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_post_empty", empty, 1);
    cycle(1, 0, 8'h3C);
    cycle(0, 1, 8'h00);
    chk("t6_read_3c", data_out, 8'h3C);
    chk("t6_final_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
